uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between NUM_REQ byte producers, e.g. the core MMIO console and a debug/trace unit.
- Accepts one byte at a time from the requesters, using round-robin arbitration.
- Drives uart_tx tx_valid/tx_data_in and tracks tx_busy, so each byte is issued only when the transmitter is free.
- Includes a watchdog that recovers the arbiter if uart_tx never acknowledges a byte.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_WIDTH, 1, width of grant_id; must satisfy 2**ID_WIDTH >= NUM_REQ.
- BUSY_TIMEOUT, 16, clock cycles to wait for tx_busy to rise after issue before aborting.
- GAP_CYCLES, 0, idle cycles inserted after each byte (used only with UART_TX_ARB_GAP_EN).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  requester i has a byte pending.
- req_data  input  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot; byte i is accepted on a clock edge where req_valid[i] and req_ready[i] are both high.
- grant_id  output  ID_WIDTH  index of the requester that owns the current/last byte.
- tx_valid  output  1  to uart_tx; single-cycle issue pulse.
- tx_data_in  output  8  to uart_tx; held stable from issue until the byte completes.
- tx_busy  input  1  from uart_tx.
- arb_busy  output  1  high whenever state != IDLE.
- tx_timeout  output  1  one-cycle pulse when the watchdog aborts a byte.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx_valid=0, tx_data_in=8'h00, grant_id=0, last_grant=NUM_REQ-1, tx_timeout=0, wait counter=0. req_ready is 0 while reset is asserted.
- req_ready is combinational. It is nonzero only in IDLE, and then only when tx_busy=0. It is the one-hot round-robin winner among req_valid, searching from last_grant+1 upward with wrap to 0. All zero if no request is pending.
- IDLE, on an accept edge:
  - tx_data_in <= winner's byte.
  - grant_id <= winner; last_grant <= winner.
  - tx_valid <= 1; state -> ISSUE.
- ISSUE (exactly 1 cycle, tx_valid=1): tx_valid <= 0; counter cleared; state -> WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches BUSY_TIMEOUT-1 with tx_busy still 0: tx_timeout pulses 1 cycle, state -> IDLE.
  - The aborted byte is dropped and the next grant still rotates.
- WAIT_DONE: tx_busy=0 -> IDLE (or GAP when the macro is enabled). Duration is unbounded: a frame lasts about 10*CLOCK_FREQUENCY/BAUD_RATE cycles.
- Latency: accept at edge N -> tx_valid high during cycle N+1. The earliest next accept is the first IDLE cycle after tx_busy falls.
- A requester that drops req_valid without a handshake is simply not granted; there is no penalty.
- A change to req_valid/req_data after acceptance has no effect on the byte in flight.
- If tx_busy=1 while in IDLE (external use), no grant is given until it falls.
- Simultaneous requests: strict rotation. With all NUM_REQ requesters continuously valid, each is served once per NUM_REQ bytes.
- Reset asserted mid-frame returns the arbiter to IDLE immediately with tx_valid=0. The uart_tx frame in progress is not the arbiter's concern.

Optional Feature:
- Macro: UART_TX_ARB_GAP_EN.
- Defined:
  - State GAP is added after WAIT_DONE and holds for GAP_CYCLES cycles, then goes to IDLE.
  - arb_busy stays high during GAP.
  - GAP_CYCLES=0 means GAP lasts 0 cycles (direct to IDLE).
- Not defined: GAP does not exist; GAP_CYCLES is ignored; WAIT_DONE goes directly to IDLE.

Test Plan:
- Single request, uart_tx real instance, 25.125 MHz / 9600 baud: req_valid=01, byte 8'hCC -> req_ready=01 for 1 cycle, tx_valid one cycle later, serial line carries 0,0,0,1,1,0,0,1,1,1, arb_busy falls after tx_busy falls.
- Contention: req_valid=11 held, req 0 data 8'h41, req 1 data 8'h42, last_grant reset to 1 -> bytes transmitted 41,42,41,42; grant_id toggles 0,1,0,1.
- Watchdog: stub tx_busy tied 0, BUSY_TIMEOUT=16, request 8'h55 -> tx_timeout pulses exactly 16 cycles after the ISSUE cycle, state returns to IDLE, and the next request is accepted.
- Reset mid-frame: assert reset during WAIT_DONE -> tx_valid=0, arb_busy=0, req_ready=0 asynchronously. After release, a pending request 8'hA5 is granted to requester 0.
- Busy gating: hold tx_busy=1 externally with req_valid=01 -> req_ready stays 0. When tx_busy drops, accept occurs that cycle.
- With UART_TX_ARB_GAP_EN and GAP_CYCLES=5: back-to-back requests -> exactly 5 cycles between tx_busy falling and the next req_ready pulse. Without the macro -> 0 cycles.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers, with a tx_busy watchdog.
// Optional inter-byte idle gap is enabled by defining UART_TX_ARB_GAP_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ID_WIDTH     = 1,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [ID_WIDTH-1:0]  grant_id,
  output logic                 tx_valid,
  output logic [7:0]           tx_data_in,
  input  logic                 tx_busy,
  output logic                 arb_busy,
  output logic                 tx_timeout
);

  // One counter serves both the watchdog and the gap, so size it for the larger.
  localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);

`ifdef UART_TX_ARB_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
`endif

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [ID_WIDTH-1:0] last_grant;
  logic [ID_WIDTH-1:0] winner;
  logic [7:0]          win_data;
  logic [NUM_REQ-1:0]  onehot;
  logic                found;
  logic                grant_en;
  logic                accept;

  // Two-pass search: first above last_grant, then wrap to index 0.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_data = 8'h00;
    onehot   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i > int'(last_grant))) begin
        found     = 1'b1;
        winner    = ID_WIDTH'(i);
        win_data  = req_data[8*i +: 8];
        onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found     = 1'b1;
        winner    = ID_WIDTH'(i);
        win_data  = req_data[8*i +: 8];
        onehot[i] = 1'b1;
      end
    end
  end

  // reset gates req_ready so no handshake is advertised while held in reset.
  assign grant_en  = reset && (state == IDLE) && !tx_busy;
  assign req_ready = grant_en ? onehot : '0;
  assign accept    = |req_ready;
  assign arb_busy  = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_timeout = 1'b0;
    case (state)
      IDLE:      if (accept) state_next = ISSUE;
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt == BUSY_LAST) begin
          tx_timeout = 1'b1;
          state_next = IDLE;
        end
      end
`ifdef UART_TX_ARB_GAP_EN
      WAIT_DONE: if (!tx_busy) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       if (cnt == GAP_LAST) state_next = IDLE;
`else
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
`endif
      default:   state_next = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_valid   <= 1'b0;
      tx_data_in <= 8'h00;
      grant_id   <= '0;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
      cnt        <= '0;
    end else begin
      tx_valid <= 1'b0;
      if (accept) begin
        tx_data_in <= win_data;
        grant_id   <= winner;
        last_grant <= winner;
        tx_valid   <= 1'b1;
      end
      case (state)
        ISSUE:     cnt <= '0;
        WAIT_BUSY: if (!tx_busy) cnt <= cnt + CNT_W'(1);
        WAIT_DONE: cnt <= '0;
`ifdef UART_TX_ARB_GAP_EN
        GAP:       cnt <= cnt + CNT_W'(1);
`endif
        default:   cnt <= cnt;
      endcase
    end
  end

endmodule
